// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: oversamples the panel link, rebuilds each latched row pair
// and streams it out as framebuffer pixel writes with length/overrun checks.
module hub75_rx_capture #(
    parameter int COLS        = 64,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hub_clk,
    input  logic              hub_lat,
    input  logic              hub_oe,
    input  logic [ADDR_W-1:0] hub_addr,
    input  logic [5:0]        hub_rgb,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_row,
    output logic [5:0]        wr_col,
    output logic [5:0]        wr_rgb,
    output logic              frame_done,
    output logic              oe_active,
    output logic              len_err,
    output logic              ovf_err,
    input  logic              err_clr
);

    localparam int SW = 3 + ADDR_W + 6;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
    logic [SW-1:0]                  in_vec, s_last;
    logic                           s_clk, s_lat, s_oe;
    logic [ADDR_W-1:0]              s_addr;
    logic [5:0]                     s_rgb;

    logic                           clk_prev_q, clk_prev_d;
    logic                           lat_prev_q, lat_prev_d;
    logic [COLS-1:0][5:0]           line_q, line_d;
    logic [COLS-1:0][5:0]           drain_q, drain_d;
    logic [6:0]                     cnt_q, cnt_d, cnt_shift;
    logic [5:0]                     col_q, col_d;
    logic [ADDR_W-1:0]              row_q, row_d;
    logic                           frame_done_q, frame_done_d;
    logic                           len_err_q, len_err_d;
    logic                           ovf_err_q, ovf_err_d;
    logic                           clk_rise, lat_rise, commit, last_beat;

    // OE is carried inverted so the all-zero synchronizer reset reads as "inactive".
    assign in_vec = {hub_clk, hub_lat, ~hub_oe, hub_addr, hub_rgb};
    assign s_last = sync_q[SYNC_STAGES-1];
    assign s_rgb  = s_last[5:0];
    assign s_addr = s_last[6 +: ADDR_W];
    assign s_oe   = s_last[6 + ADDR_W];
    assign s_lat  = s_last[7 + ADDR_W];
    assign s_clk  = s_last[8 + ADDR_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            clk_prev_q   <= 1'b0;
            lat_prev_q   <= 1'b0;
            line_q       <= '0;
            drain_q      <= '0;
            cnt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            clk_prev_q   <= clk_prev_d;
            lat_prev_q   <= lat_prev_d;
            line_q       <= line_d;
            drain_q      <= drain_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            len_err_q    <= len_err_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lat_rise) state_d = DRAIN;
            DRAIN:   if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], in_vec};
        clk_prev_d = s_clk;
        lat_prev_d = s_lat;
        clk_rise   = s_clk & ~clk_prev_q;
        lat_rise   = s_lat & ~lat_prev_q;
        last_beat  = (state_q == DRAIN) && (col_q == 6'(COLS - 1));

        // Newest sample enters column 0, so the first pixel after a latch ends at COLS-1.
        line_d    = clk_rise ? {line_q[COLS-2:0], s_rgb} : line_q;
        cnt_shift = (clk_rise && cnt_q != 7'd127) ? cnt_q + 7'd1 : cnt_q;
        cnt_d     = lat_rise ? 7'd0 : cnt_shift;

        // Committing uses line_d/cnt_shift so a coincident shift lands in the row.
        commit  = lat_rise && (state_q == IDLE);
        drain_d = commit ? line_d : drain_q;
        row_d   = commit ? s_addr : row_q;

        col_d = col_q;
        if (commit)
            col_d = 6'd0;
        else if (state_q == DRAIN && !last_beat)
            col_d = col_q + 6'd1;

        frame_done_d = last_beat && (row_q == '1);
        len_err_d    = (commit && cnt_shift != 7'(COLS)) | (len_err_q & ~err_clr);
        ovf_err_d    = (lat_rise && state_q == DRAIN) | (ovf_err_q & ~err_clr);
    end

    always_comb begin
        wr_en = (state_q == DRAIN);
    end

    assign wr_row     = row_q;
    assign wr_col     = col_q;
    assign wr_rgb     = drain_q[col_q];
    assign frame_done = frame_done_q;
    assign oe_active  = s_oe;
    assign len_err    = len_err_q;
    assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Bench for hub75_rx_capture: random pixel rows checked against a history-based
// model of what the line buffer must hold at each latch.
module tb_hub75_rx_capture;
  localparam int COLS = 64;
  localparam int AW   = 4;
  localparam int HOLD = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          hub_clk = 1'b0, hub_lat = 1'b0, hub_oe = 1'b1, err_clr = 1'b0;
  logic [AW-1:0] hub_addr = '0;
  logic [5:0]    hub_rgb = '0;
  logic          wr_en, frame_done, oe_active, len_err, ovf_err;
  logic [AW-1:0] wr_row;
  logic [5:0]    wr_col, wr_rgb;

  hub75_rx_capture #(.COLS(COLS), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
    .hub_addr(hub_addr), .hub_rgb(hub_rgb), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_rgb(wr_rgb), .frame_done(frame_done), .oe_active(oe_active),
    .len_err(len_err), .ovf_err(ovf_err), .err_clr(err_clr));

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] row; logic [5:0] col; logic [5:0] rgb; int t; } wr_t;

  int         total = 0, bad = 0, cyc = 0;
  wr_t        wq[$], mw;
  int         fd[$];
  logic [5:0] hist[$];
  logic [5:0] exp_row[COLS];
  logic [5:0] exp_all[16][COLS];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_en === 1'b1) begin
      mw.row = wr_row; mw.col = wr_col; mw.rgb = wr_rgb; mw.t = cyc;
      wq.push_back(mw);
    end
    if (frame_done === 1'b1) fd.push_back(cyc);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Model: column k of the line buffer is the k-th most recent sample (0 if none yet).
  function automatic logic [5:0] line_at(int k);
    return (k < hist.size()) ? hist[k] : 6'd0;
  endfunction

  task automatic snap();
    for (int k = 0; k < COLS; k++) exp_row[k] = line_at(k);
  endtask

  task automatic shift_px(input logic [5:0] v);
    hub_rgb = v; hub_clk = 1'b1; hist.push_front(v);
    repeat (HOLD) @(negedge clk);
    hub_clk = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic latch();
    hub_lat = 1'b1;
    repeat (HOLD) @(negedge clk);
    hub_lat = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic wait_writes(input int n);
    int b = 0;
    while (wq.size() < n && b < 400) begin @(negedge clk); b++; end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({wr_en, wr_row, wr_col, wr_rgb, frame_done, oe_active, len_err, ovf_err} !== '0) begin
      bad++;
      $display("FAIL reset_state: got en=%b row=%0d col=%0d rgb=%h fd=%b oe=%b le=%b oe_err=%b, want all 0",
               wr_en, wr_row, wr_col, wr_rgb, frame_done, oe_active, len_err, ovf_err);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (oe_active !== 1'b0 || wr_en !== 1'b0) begin
      bad++; $display("FAIL reset_release: got oe_active=%b wr_en=%b, want 0 0", oe_active, wr_en);
    end
  endtask

  task automatic test_full_row();
    hub_addr = 4'd5; wq.delete();
    for (int p = 0; p < COLS; p++) shift_px(6'(p));
    snap(); latch(); wait_writes(COLS);
    total++;
    if (wq.size() !== COLS) begin bad++; $display("FAIL full_row_count: got %0d want %0d", wq.size(), COLS); end
    for (int k = 0; k < wq.size() && k < COLS; k++) begin
      total++;
      if (wq[k].row !== 4'd5 || wq[k].col !== 6'(k) || wq[k].rgb !== 6'(COLS - 1 - k) ||
          wq[k].rgb !== exp_row[k] || (k > 0 && wq[k].t !== wq[k-1].t + 1)) begin
        bad++;
        $display("FAIL full_row_beat %0d: got row=%0d col=%0d rgb=%h t=%0d, want row=5 col=%0d rgb=%h contiguous",
                 k, wq[k].row, wq[k].col, wq[k].rgb, wq[k].t, k, exp_row[k]);
      end
    end
    total++;
    if (len_err !== 1'b0 || wr_en !== 1'b0 || wr_col !== 6'(COLS - 1)) begin
      bad++; $display("FAIL full_row_idle: got len_err=%b wr_en=%b wr_col=%0d, want 0 0 %0d", len_err, wr_en, wr_col, COLS - 1);
    end
  endtask

  task automatic test_short_row();
    logic [AW-1:0] a;
    a = AW'($urandom); hub_addr = a; wq.delete();
    for (int p = 0; p < 60; p++) shift_px(6'($urandom));
    snap(); latch(); wait_writes(COLS);
    total++;
    if (wq.size() !== COLS) begin bad++; $display("FAIL short_row_count: got %0d want %0d", wq.size(), COLS); end
    for (int k = 0; k < wq.size() && k < COLS; k++) begin
      total++;
      if (wq[k].row !== a || wq[k].col !== 6'(k) || wq[k].rgb !== exp_row[k]) begin
        bad++;
        $display("FAIL short_row_beat %0d: got row=%0d col=%0d rgb=%h, want row=%0d col=%0d rgb=%h",
                 k, wq[k].row, wq[k].col, wq[k].rgb, a, k, exp_row[k]);
      end
    end
    total++;
    if (len_err !== 1'b1) begin bad++; $display("FAIL short_row_len_err: got %b want 1", len_err); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    total++;
    if (len_err !== 1'b0) begin bad++; $display("FAIL short_row_clear: got %b want 0", len_err); end
  endtask

  task automatic test_overflow();
    hub_addr = 4'd3; wq.delete();
    for (int p = 0; p < COLS; p++) shift_px(6'($urandom));
    snap(); latch();
    repeat (2) @(negedge clk);
    hub_addr = 4'd9;
    latch();
    wait_writes(COLS);
    total++;
    if (wq.size() !== COLS) begin bad++; $display("FAIL ovf_count: got %0d want %0d", wq.size(), COLS); end
    for (int k = 0; k < wq.size() && k < COLS; k++) begin
      total++;
      if (wq[k].row !== 4'd3 || wq[k].col !== 6'(k) || wq[k].rgb !== exp_row[k]) begin
        bad++;
        $display("FAIL ovf_beat %0d: got row=%0d col=%0d rgb=%h, want row=3 col=%0d rgb=%h",
                 k, wq[k].row, wq[k].col, wq[k].rgb, k, exp_row[k]);
      end
    end
    total++;
    if (ovf_err !== 1'b1 || len_err !== 1'b0) begin
      bad++; $display("FAIL ovf_flags: got ovf_err=%b len_err=%b, want 1 0", ovf_err, len_err);
    end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    total++;
    if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf_err); end
  endtask

  task automatic test_frame();
    int i;
    wq.delete(); fd.delete();
    for (int r = 0; r < 16; r++) begin
      hub_addr = AW'(r);
      for (int p = 0; p < COLS; p++) shift_px(6'($urandom));
      snap();
      for (int k = 0; k < COLS; k++) exp_all[r][k] = exp_row[k];
      latch(); wait_writes((r + 1) * COLS);
    end
    total++;
    if (wq.size() !== 16 * COLS) begin bad++; $display("FAIL frame_count: got %0d want %0d", wq.size(), 16 * COLS); end
    for (i = 0; i < wq.size() && i < 16 * COLS; i++) begin
      total++;
      if (wq[i].row !== AW'(i / COLS) || wq[i].col !== 6'(i % COLS) || wq[i].rgb !== exp_all[i / COLS][i % COLS]) begin
        bad++;
        $display("FAIL frame_beat %0d: got row=%0d col=%0d rgb=%h, want row=%0d col=%0d rgb=%h",
                 i, wq[i].row, wq[i].col, wq[i].rgb, i / COLS, i % COLS, exp_all[i / COLS][i % COLS]);
      end
    end
    total++;
    if (fd.size() !== 1) begin
      bad++; $display("FAIL frame_done_count: got %0d pulses want 1", fd.size());
    end else if (wq.size() > 0) begin
      total++;
      if (fd[0] !== wq[wq.size() - 1].t + 1) begin
        bad++; $display("FAIL frame_done_time: got cycle %0d want %0d", fd[0], wq[wq.size() - 1].t + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b = 0, n;
    hub_addr = 4'd7;
    for (int p = 0; p < COLS; p++) shift_px(6'($urandom));
    wq.delete(); latch();
    while (wq.size() < 20 && b < 400) begin @(negedge clk); #1; b++; end
    rst = 1'b0; #1;
    n = wq.size();
    total++;
    if (n !== 20) begin bad++; $display("FAIL reset_mid_reach: got %0d beats want 20", n); end
    total++;
    if ({wr_en, wr_row, wr_col, wr_rgb, frame_done, len_err, ovf_err} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: got en=%b row=%0d col=%0d rgb=%h fd=%b, want all 0",
               wr_en, wr_row, wr_col, wr_rgb, frame_done);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1; hist.delete();
    repeat (100) @(negedge clk);
    total++;
    if (wq.size() !== n) begin bad++; $display("FAIL reset_mid_no_more: got %0d writes want %0d", wq.size(), n); end
    hub_addr = 4'd2; wq.delete();
    for (int p = 0; p < COLS; p++) shift_px(6'($urandom));
    snap(); latch(); wait_writes(COLS);
    total++;
    if (wq.size() !== COLS) begin bad++; $display("FAIL reset_after_count: got %0d want %0d", wq.size(), COLS); end
    for (int k = 0; k < wq.size() && k < COLS; k++) begin
      total++;
      if (wq[k].row !== 4'd2 || wq[k].col !== 6'(k) || wq[k].rgb !== exp_row[k]) begin
        bad++;
        $display("FAIL reset_after_beat %0d: got row=%0d col=%0d rgb=%h, want row=2 col=%0d rgb=%h",
                 k, wq[k].row, wq[k].col, wq[k].rgb, k, exp_row[k]);
      end
    end
  endtask

  task automatic test_oe();
    hub_oe = 1'b0;
    @(posedge clk); #1;
    total++;
    if (oe_active !== 1'b0) begin bad++; $display("FAIL oe_early_on: got %b want 0", oe_active); end
    @(posedge clk); #1;
    total++;
    if (oe_active !== 1'b1) begin bad++; $display("FAIL oe_on: got %b want 1", oe_active); end
    @(negedge clk);
    hub_oe = 1'b1;
    @(posedge clk); #1;
    total++;
    if (oe_active !== 1'b1) begin bad++; $display("FAIL oe_early_off: got %b want 1", oe_active); end
    @(posedge clk); #1;
    total++;
    if (oe_active !== 1'b0) begin bad++; $display("FAIL oe_off: got %b want 0", oe_active); end
    @(negedge clk);
  endtask

  task automatic test_coincident();
    logic [AW-1:0] a;
    logic [5:0]    v;
    a = AW'($urandom); hub_addr = a; wq.delete();
    for (int p = 0; p < COLS - 1; p++) shift_px(6'($urandom));
    v = 6'($urandom);
    hist.push_front(v); snap();
    hub_rgb = v; hub_clk = 1'b1; hub_lat = 1'b1;
    repeat (HOLD) @(negedge clk);
    hub_clk = 1'b0; hub_lat = 1'b0;
    repeat (HOLD) @(negedge clk);
    wait_writes(COLS);
    total++;
    if (wq.size() !== COLS) begin bad++; $display("FAIL coinc_count: got %0d want %0d", wq.size(), COLS); end
    for (int k = 0; k < wq.size() && k < COLS; k++) begin
      total++;
      if (wq[k].row !== a || wq[k].col !== 6'(k) || wq[k].rgb !== exp_row[k]) begin
        bad++;
        $display("FAIL coinc_beat %0d: got row=%0d col=%0d rgb=%h, want row=%0d col=%0d rgb=%h",
                 k, wq[k].row, wq[k].col, wq[k].rgb, a, k, exp_row[k]);
      end
    end
    total++;
    if (len_err !== 1'b0) begin bad++; $display("FAIL coinc_len_err: got %b want 0", len_err); end
  endtask

  initial begin
    test_reset();
    test_full_row();
    test_short_row();
    test_overflow();
    test_frame();
    test_reset_mid();
    test_oe();
    test_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hub75_rx_capture.md
Name: hub75_rx_capture

Overview:
- Receiving end of the HUB75 LED-matrix link that the panel driver transmits.
- Oversamples the shift clock, latch, OE, row address and the six colour lines in the system clock domain.
- Reassembles each latched row pair and streams it out on a pixel write port into a framebuffer.
- Used as a loopback monitor and checker for the matrix driver in simulation and on the FPGA.

Parameters:
- COLS, 64, pixels shifted per row before each latch.
- ADDR_W, 4, row address width (lines A..D); row pairs = 2**ADDR_W.
- SYNC_STAGES, 2, synchronizer flops on every HUB75 input (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- hub_clk  in  1  HUB75 shift clock; data sampled on its rising edge.
- hub_lat  in  1  HUB75 latch; rising edge commits the row.
- hub_oe  in  1  HUB75 output enable, active-low.
- hub_addr  in  ADDR_W  row address {D,C,B,A}.
- hub_rgb  in  6  {B1,G1,R1,B0,G0,R0}.
- wr_en  out  1  framebuffer write strobe.
- wr_row  out  ADDR_W  row pair being written.
- wr_col  out  6  column, 0..COLS-1.
- wr_rgb  out  6  pixel pair data, same bit order as hub_rgb.
- frame_done  out  1  one-cycle pulse when row 2**ADDR_W-1 finishes draining.
- oe_active  out  1  synchronized ~hub_oe.
- len_err  out  1  sticky: latch seen with shift count != COLS.
- ovf_err  out  1  sticky: latch seen while draining.
- err_clr  in  1  clears len_err and ovf_err.

Behaviour:
- Reset (rst=0, async): wr_en=0, wr_row=0, wr_col=0, wr_rgb=0, frame_done=0, oe_active=0, len_err=0, ovf_err=0. State IDLE, shift count 0, line buffer 0, synchronizers 0.
- Input sync: all HUB75 inputs pass through SYNC_STAGES flops. Edges are detected on the last stage against a one-cycle-delayed copy. Data and address are taken from the same stage, so they align with the edge.
- Input timing: hub_clk and hub_lat must each be high and low for at least SYNC_STAGES+1 clk cycles. Faster input is unsupported and unchecked.
- Shift:
  - On each detected hub_clk rise, hub_rgb shifts into a COLS x 6 line buffer, in any state.
  - The first value shifted after a latch ends at column COLS-1; the last value ends at column 0.
  - Shift count (7 bits) increments and saturates at 127.
- Latch in IDLE (hub_lat rise detected):
  - The line buffer is copied into a drain buffer and hub_addr is captured into wr_row.
  - If shift count != COLS, len_err sets; the drain still proceeds with buffer contents.
  - Shift count clears to 0 and the state goes to DRAIN.
- DRAIN:
  - Starts the cycle after the latch edge.
  - wr_en=1 for exactly COLS consecutive cycles, wr_col = 0,1,..,COLS-1, with wr_rgb = drain_buffer[wr_col].
  - On the last beat the state returns to IDLE. wr_en=0 on the following cycle.
- Latch during DRAIN: ovf_err sets. The latch is otherwise ignored: no copy and wr_row unchanged. Shift count still clears to 0. The current drain completes unaffected.
- frame_done: pulses in the cycle after the last beat of a drain whose wr_row = 2**ADDR_W-1.
- Outputs when idle: wr_col and wr_rgb hold their last values; consumers qualify with wr_en.
- Errors: sticky until err_clr=1. If err_clr and a new error occur in the same cycle, the error wins (flag stays 1).
- Reset mid-drain: all outputs return to reset values immediately. The partial row is discarded; no further wr_en.
- Latch and shift in the same cycle: the shift applies first, so the new sample is included in the committed row and counted in the length check.

Test Plan:
- Shift 64 pixels with value = col index mod 64 on R0..B1, hub_addr=5, then pulse lat -> 64 writes, wr_row=5, wr_col 0..63 contiguous, wr_rgb[k] = value shifted at position 63-k, len_err=0.
- Shift 60 pixels then latch -> drain of 64 writes still occurs, len_err=1; err_clr pulse -> len_err=0.
- Latch row 3, then second latch 10 cycles later during drain -> exactly 64 writes, all wr_row=3, ovf_err=1.
- Send rows 0..15 each with 64 shifts -> 1024 writes, a single frame_done pulse one cycle after the row-15 last beat.
- Assert rst low at drain beat 20 -> wr_en drops asynchronously, no further writes; after release, the next full row drains normally.
- Toggle hub_oe 1->0->1 -> oe_active follows inverted after SYNC_STAGES cycles. A shift coincident with a latch -> that pixel is included and count=64 gives len_err=0.
